calc_seq_ctrl: RTL

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

---
 rtl/calc_seq_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_seq_ctrl.sv
// Sequenced sign-magnitude calculator: IDLE -> CONV -> EXEC -> DONE, ADD/SUB in one EXEC cycle.
// Define CALC_MUL_EN to build the 7-cycle shift-add multiplier; otherwise MUL reports Err.
module calc_seq_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_op,
    input  logic [6:0] i_a_mag,
    input  logic       i_a_sign,
    input  logic [6:0] i_b_mag,
    input  logic       i_b_sign,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result,
    output logic       o_ovf,
    output logic       o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
`ifdef CALC_MUL_EN
    localparam logic [1:0] OP_MUL = 2'b10;
`endif

    // Negative zero collapses to 0x00 because 0 - 0 is still 0.
    function automatic logic [7:0] sm_to_tc(input logic [6:0] mag, input logic sign);
        return sign ? (8'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_op;
    logic [6:0] r_a_mag;
    logic       r_a_sign;
    logic [6:0] r_b_mag;
    logic       r_b_sign;
    logic [7:0] r_a_tc;
    logic [7:0] r_b_tc;
    logic       w_exec_done;
    logic [8:0] w_sum9;
    logic [8:0] w_dif9;
    logic [7:0] w_res;
    logic       w_ovf;
    logic       w_err;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_load_res;

`ifdef CALC_MUL_EN
    logic [13:0] r_mcand;
    logic [6:0]  r_mplier;
    logic [13:0] r_prod;
    logic [2:0]  r_cnt;
    logic [13:0] w_prod_nxt;
    logic [13:0] w_prod_tc;
    logic        w_mul_neg;
    logic        w_mul_ovf;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_CONV;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CONV: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_exec_done) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, sign conversion and multiplier stepping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op     <= 2'd0;
            r_a_mag  <= 7'd0;
            r_a_sign <= 1'b0;
            r_b_mag  <= 7'd0;
            r_b_sign <= 1'b0;
            r_a_tc   <= 8'd0;
            r_b_tc   <= 8'd0;
`ifdef CALC_MUL_EN
            r_mcand  <= 14'd0;
            r_mplier <= 7'd0;
            r_prod   <= 14'd0;
            r_cnt    <= 3'd0;
`endif
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_op     <= i_op;
                r_a_mag  <= i_a_mag;
                r_a_sign <= i_a_sign;
                r_b_mag  <= i_b_mag;
                r_b_sign <= i_b_sign;
            end
            if (r_state == S_CONV) begin
                r_a_tc   <= sm_to_tc(r_a_mag, r_a_sign);
                r_b_tc   <= sm_to_tc(r_b_mag, r_b_sign);
`ifdef CALC_MUL_EN
                r_mcand  <= {7'd0, r_a_mag};
                r_mplier <= r_b_mag;
                r_prod   <= 14'd0;
                r_cnt    <= 3'd0;
`endif
            end
`ifdef CALC_MUL_EN
            if ((r_state == S_EXEC) && (r_op == OP_MUL)) begin
                r_prod   <= w_prod_nxt;
                r_mcand  <= {r_mcand[12:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[6:1]};
                r_cnt    <= r_cnt + 3'd1;
            end
`endif
        end
    end

`ifdef CALC_MUL_EN
    // One multiplier bit per EXEC cycle; the seventh step is folded into the result
    always_comb begin
        w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
        w_mul_neg  = (r_a_sign ^ r_b_sign) && (w_prod_nxt != 14'd0);
        w_prod_tc  = w_mul_neg ? (14'd0 - w_prod_nxt) : w_prod_nxt;
        w_mul_ovf  = w_mul_neg ? (w_prod_nxt > 14'd128) : (w_prod_nxt > 14'd127);
        w_exec_done = (r_op == OP_MUL) ? (r_cnt == 3'd6) : 1'b1;
    end
`else
    assign w_exec_done = 1'b1;
`endif

    // Result selection for the operation finishing this cycle
    always_comb begin
        w_sum9 = {r_a_tc[7], r_a_tc} + {r_b_tc[7], r_b_tc};
        w_dif9 = {r_a_tc[7], r_a_tc} - {r_b_tc[7], r_b_tc};
        w_res  = 8'd0;
        w_ovf  = 1'b0;
        w_err  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_sum9[7:0];
                w_ovf = w_sum9[8] ^ w_sum9[7];
            end
            OP_SUB: begin
                w_res = w_dif9[7:0];
                w_ovf = w_dif9[8] ^ w_dif9[7];
            end
`ifdef CALC_MUL_EN
            OP_MUL: begin
                w_res = w_prod_tc[7:0];
                w_ovf = w_mul_ovf;
            end
`endif
            default: begin
                w_res = 8'd0;
                w_ovf = 1'b0;
                w_err = 1'b1;
            end
        endcase
    end

    // Output decode, one cycle ahead of the registered outputs
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_load_res = (r_state == S_EXEC) && w_exec_done;
    end

    // Registered outputs; results change only on entry to DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= 8'd0;
            o_ovf    <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_busy <= w_busy_nxt;
            o_done <= w_done_nxt;
            if (w_load_res) begin
                o_result <= w_res;
                o_ovf    <= w_ovf;
                o_err    <= w_err;
            end
        end
    end

endmodule
